// File: rtl/fric_xactor_p_if.sv
// FRIC transactor bus bundle: the serial beat lines plus the TX request and
// RX FIFO head handshakes.
//   slave  : transactor side (drives fric_out, tx_ready and all rx_* outputs)
//   master : client side (drives fric_in, tx_* request fields and rx_ready)
interface fric_xactor_p_if #(
    parameter int DW         = 8,
    parameter int NBEATS     = 2,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [DW-1:0]        fric_in;
    logic [DW-1:0]        fric_out;

    logic                 tx_valid;
    logic                 tx_ready;
    logic [3:0]           tx_type;
    logic [3:0]           tx_port;
    logic [DW-1:0]        tx_addr;
    logic [DW*NBEATS-1:0] tx_data;

    logic                 rx_valid;
    logic                 rx_ready;
    logic [3:0]           rx_type;
    logic [3:0]           rx_port;
    logic [DW-1:0]        rx_addr;
    logic [DW*NBEATS-1:0] rx_data;
    logic [CW-1:0]        rx_count;
    logic                 rx_ovf;
    logic                 rx_err;

    modport slave (
        input  fric_in, tx_valid, tx_type, tx_port, tx_addr, tx_data, rx_ready,
        output fric_out, tx_ready, rx_valid, rx_type, rx_port, rx_addr, rx_data,
               rx_count, rx_ovf, rx_err
    );

    modport master (
        output fric_in, tx_valid, tx_type, tx_port, tx_addr, tx_data, rx_ready,
        input  fric_out, tx_ready, rx_valid, rx_type, rx_port, rx_addr, rx_data,
               rx_count, rx_ovf, rx_err
    );
endinterface

// File: rtl/fric_xactor_p.sv
// FRIC transactor: serialises TX requests into header/address/data beats on
// fric_out and deframes fric_in beats into a first-word-fall-through RX FIFO.
//   clk  : single clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : fric_xactor_p_if.slave (beat lines, TX request, RX FIFO head)
//
// TX states                     | RX states
//   IDLE | ready for a request  |   IDLE | waiting for a header beat
//   HDR  | header loads next    |   ADDR | next beat is the address
//   ADDR | address loads next   |   DATA | collecting data beats, LSB first
//   DATA | data beats load next |
module fric_xactor_p #(
    parameter int DW         = 8,
    parameter int NBEATS     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    fric_xactor_p_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(NBEATS) + 1;
    localparam int WW = DW * NBEATS;
    localparam int EW = 8 + DW + WW;

    function automatic logic type_ok(input logic [3:0] t);
        return (t >= 4'd1) && (t <= 4'd4);
    endfunction

    function automatic logic has_data(input logic [3:0] t);
        return (t == 4'd1) || (t == 4'd4);
    endfunction

    // ---------------- TX ----------------
    typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_ADDR, TX_DATA} tx_state_t;
    tx_state_t     tx_state, tx_state_nxt;
    logic [BW-1:0] tx_beat, tx_beat_nxt;
    logic [DW-1:0] fric_out_q, fric_out_nxt;
    logic [3:0]    t_type, t_port;
    logic [DW-1:0] t_addr;
    logic [WW-1:0] t_data;
    logic          tx_accept;

    assign bus.tx_ready = (tx_state == TX_IDLE);
    assign bus.fric_out = fric_out_q;
    assign tx_accept    = bus.tx_valid && bus.tx_ready;

    always_comb begin
        tx_state_nxt = tx_state;
        tx_beat_nxt  = tx_beat;
        fric_out_nxt = '0;
        case (tx_state)
            TX_IDLE: if (tx_accept && type_ok(bus.tx_type)) tx_state_nxt = TX_HDR;
            TX_HDR: begin
                fric_out_nxt[7:0] = {t_type, t_port};
                tx_state_nxt      = TX_ADDR;
            end
            TX_ADDR: begin
                fric_out_nxt = t_addr;
                tx_beat_nxt  = '0;
                tx_state_nxt = has_data(t_type) ? TX_DATA : TX_IDLE;
            end
            TX_DATA: begin
                // t_data shifts down one beat per cycle, so the low beat is next
                fric_out_nxt = t_data[DW-1:0];
                if (tx_beat == BW'(NBEATS - 1)) tx_state_nxt = TX_IDLE;
                else                            tx_beat_nxt  = tx_beat + BW'(1);
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state   <= TX_IDLE;
            tx_beat    <= '0;
            fric_out_q <= '0;
            t_type     <= '0;
            t_port     <= '0;
            t_addr     <= '0;
            t_data     <= '0;
        end else begin
            tx_state   <= tx_state_nxt;
            tx_beat    <= tx_beat_nxt;
            fric_out_q <= fric_out_nxt;
            if (tx_accept) begin
                t_type <= bus.tx_type;
                t_port <= bus.tx_port;
                t_addr <= bus.tx_addr;
                t_data <= bus.tx_data;
            end else if (tx_state == TX_DATA) begin
                t_data <= t_data >> DW;
            end
        end
    end

    // ---------------- RX ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_ADDR, RX_DATA} rx_state_t;
    rx_state_t     rx_state, rx_state_nxt;
    logic [DW-1:0] fric_q;
    logic [3:0]    r_type, r_port;
    logic [DW-1:0] r_addr;
    logic [WW-1:0] r_data, wr_word;
    logic [BW-1:0] r_beat, r_beat_nxt;
    logic          hdr_valid, push, err_nxt, rx_err_q;
    logic [EW-1:0] wr_entry;

    // upper header bits must be zero; for DW=8 there are none
    assign hdr_valid = ((fric_q >> 8) == '0) && type_ok(fric_q[7:4]);

    always_comb begin
        rx_state_nxt = rx_state;
        r_beat_nxt   = r_beat;
        push         = 1'b0;
        err_nxt      = 1'b0;
        wr_word      = r_data;
        case (rx_state)
            RX_IDLE: begin
                if (hdr_valid)            rx_state_nxt = RX_ADDR;
                else if (fric_q != '0)    err_nxt      = 1'b1;
            end
            RX_ADDR: begin
                r_beat_nxt = '0;
                if (has_data(r_type)) begin
                    rx_state_nxt = RX_DATA;
                end else begin
                    push         = 1'b1;
                    rx_state_nxt = RX_IDLE;
                end
            end
            RX_DATA: begin
                // r_data is cleared at the header, so OR-merging is safe
                wr_word = r_data | (WW'(fric_q) << (DW * r_beat));
                if (r_beat == BW'(NBEATS - 1)) begin
                    push         = 1'b1;
                    rx_state_nxt = RX_IDLE;
                end else begin
                    r_beat_nxt = r_beat + BW'(1);
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    assign wr_entry = {r_type, r_port, (rx_state == RX_ADDR) ? fric_q : r_addr, wr_word};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fric_q   <= '0;
            rx_state <= RX_IDLE;
            r_beat   <= '0;
            r_type   <= '0;
            r_port   <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            rx_err_q <= 1'b0;
        end else begin
            fric_q   <= bus.fric_in;
            rx_state <= rx_state_nxt;
            r_beat   <= r_beat_nxt;
            rx_err_q <= err_nxt;
            case (rx_state)
                RX_IDLE: if (hdr_valid) begin
                    r_type <= fric_q[7:4];
                    r_port <= fric_q[3:0];
                    r_data <= '0;
                end
                RX_ADDR: r_addr <= fric_q;
                RX_DATA: r_data <= wr_word;
                default: ;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, pop, do_push, rx_ovf_q;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign pop     = (count != '0) && bus.rx_ready;
    // a full FIFO still accepts when the head leaves on the same edge
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rx_ovf_q <= 1'b0;
        end else begin
            rx_ovf_q <= push && full && !pop;
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    assign bus.rx_valid = (count != '0);
    assign bus.rx_count = count;
    assign bus.rx_ovf   = rx_ovf_q;
    assign bus.rx_err   = rx_err_q;
    assign {bus.rx_type, bus.rx_port, bus.rx_addr, bus.rx_data} = mem[rd_ptr];
endmodule

// File: tb/tb_fric_xactor_p.sv
// Directed bench for fric_xactor_p: TX framing, RX deframing, FIFO full,
// overflow, header errors and mid-frame reset.
module tb_fric_xactor_p;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_err    = 0;
    int   ovf_seen = 0;
    int   err_seen = 0;

    fric_xactor_p_if #(.DW(8), .NBEATS(2), .FIFO_DEPTH(4)) bus ();

    fric_xactor_p #(.DW(8), .NBEATS(2), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.rx_ovf === 1'b1) ovf_seen++;
        if (bus.rx_err === 1'b1) err_seen++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] b);
        bus.fric_in = b;
        step();
        bus.fric_in = 8'h00;
    endtask

    task automatic rx_frame(input logic [3:0] t, input logic [3:0] p,
                            input logic [7:0] a, input logic [15:0] d);
        send_beat({t, p});
        send_beat(a);
        if (t == 4'd1 || t == 4'd4) begin
            send_beat(d[7:0]);
            send_beat(d[15:8]);
        end
    endtask

    task automatic tx_req(input logic [3:0] t, input logic [3:0] p,
                          input logic [7:0] a, input logic [15:0] d);
        bus.tx_valid = 1'b1;
        bus.tx_type  = t;
        bus.tx_port  = p;
        bus.tx_addr  = a;
        bus.tx_data  = d;
    endtask

    task automatic pop_expect(input string tag, input logic [3:0] t, input logic [3:0] p,
                              input logic [7:0] a, input logic [15:0] d);
        check({tag, " valid"}, bus.rx_valid, 1'b1);
        check({tag, " type"},  bus.rx_type,  t);
        check({tag, " port"},  bus.rx_port,  p);
        check({tag, " addr"},  bus.rx_addr,  a);
        check({tag, " data"},  bus.rx_data,  d);
        bus.rx_ready = 1'b1;
        step();
        bus.rx_ready = 1'b0;
    endtask

    initial begin
        int ovf0;
        int err0;
        bus.fric_in  = 8'h00;
        bus.tx_valid = 1'b0;
        bus.tx_type  = 4'd0;
        bus.tx_port  = 4'd0;
        bus.tx_addr  = 8'h00;
        bus.tx_data  = 16'h0000;
        bus.rx_ready = 1'b0;

        // reset values
        #12;
        check("rst fric_out", bus.fric_out, 8'h00);
        check("rst tx_ready", bus.tx_ready, 1'b1);
        check("rst rx_valid", bus.rx_valid, 1'b0);
        check("rst rx_count", bus.rx_count, 3'd0);
        check("rst rx_ovf",   bus.rx_ovf,   1'b0);
        check("rst rx_err",   bus.rx_err,   1'b0);
        rst = 1'b1;
        step();

        // TX write: beats after N+1..N+4, idle after N+5
        tx_req(4'd1, 4'd3, 8'h5A, 16'hBEEF);
        step();
        bus.tx_valid = 1'b0;
        check("wr N fric_out", bus.fric_out, 8'h00);
        check("wr N tx_ready", bus.tx_ready, 1'b0);
        step(); check("wr hdr",   bus.fric_out, 8'h13);
        step(); check("wr addr",  bus.fric_out, 8'h5A);
        step(); check("wr d0",    bus.fric_out, 8'hEF);
        step(); check("wr d1",    bus.fric_out, 8'hBE);
        step(); check("wr idle",  bus.fric_out, 8'h00);
        check("wr tx_ready", bus.tx_ready, 1'b1);

        // TX read request skips data
        tx_req(4'd2, 4'd1, 8'h42, 16'h0000);
        step();
        bus.tx_valid = 1'b0;
        step(); check("rd hdr",  bus.fric_out, 8'h21);
        step(); check("rd addr", bus.fric_out, 8'h42);
        step(); check("rd idle", bus.fric_out, 8'h00);
        check("rd tx_ready", bus.tx_ready, 1'b1);

        // invalid TX type consumed silently
        tx_req(4'd7, 4'd1, 8'h99, 16'h1234);
        step();
        bus.tx_valid = 1'b0;
        check("inv tx_ready", bus.tx_ready, 1'b1);
        step(); check("inv out1", bus.fric_out, 8'h00);
        step(); check("inv out2", bus.fric_out, 8'h00);

        // back-to-back: one idle beat between frames
        tx_req(4'd4, 4'd2, 8'h01, 16'h0302);
        step();
        tx_req(4'd2, 4'd5, 8'h07, 16'h0000);
        step(); check("b2b hdr1",  bus.fric_out, 8'h42);
        step(); check("b2b addr1", bus.fric_out, 8'h01);
        step(); check("b2b d0",    bus.fric_out, 8'h02);
        step(); check("b2b d1",    bus.fric_out, 8'h03);
        step(); check("b2b gap",   bus.fric_out, 8'h00);
        bus.tx_valid = 1'b0;
        step(); check("b2b hdr2",  bus.fric_out, 8'h25);
        step(); check("b2b addr2", bus.fric_out, 8'h07);
        step(); check("b2b idle",  bus.fric_out, 8'h00);

        // RX read request: valid two edges after the last beat
        send_beat(8'h24);
        send_beat(8'h10);
        check("rx21 early valid", bus.rx_valid, 1'b0);
        step();
        check("rx21 count", bus.rx_count, 3'd1);
        pop_expect("rx21", 4'd2, 4'd4, 8'h10, 16'h0000);
        check("rx21 empty", bus.rx_count, 3'd0);

        // five writes, no pop: overflow on fifth
        ovf0 = ovf_seen;
        for (int i = 1; i <= 5; i++)
            rx_frame(4'd1, 4'(i), 8'(8'h10 + i), 16'(16'hA0B0 + 16'h0101 * i));
        step();
        step();
        check("ovf count",  bus.rx_count, 3'd4);
        check("ovf pulses", ovf_seen - ovf0, 1);
        for (int i = 1; i <= 4; i++)
            pop_expect("ovf pop", 4'd1, 4'(i), 8'(8'h10 + i), 16'(16'hA0B0 + 16'h0101 * i));
        check("ovf drained", bus.rx_count, 3'd0);

        // full FIFO, fifth completes with a simultaneous pop
        ovf0 = ovf_seen;
        for (int i = 1; i <= 4; i++)
            rx_frame(4'd4, 4'(i), 8'(8'h30 + i), 16'(16'h1000 * i + 16'h0055));
        step();
        check("full count", bus.rx_count, 3'd4);
        send_beat(8'h45);
        send_beat(8'h35);
        send_beat(8'h55);
        bus.fric_in = 8'h50;
        step();
        bus.fric_in = 8'h00;
        bus.rx_ready = 1'b1;
        step();
        bus.rx_ready = 1'b0;
        step();
        check("full+pop count", bus.rx_count, 3'd4);
        check("full+pop no ovf", ovf_seen - ovf0, 0);
        for (int i = 2; i <= 5; i++)
            pop_expect("full pop", 4'd4, 4'(i), 8'(8'h30 + i), 16'(16'h1000 * i + 16'h0055));
        check("full drained", bus.rx_valid, 1'b0);

        // invalid header: one rx_err pulse, nothing stored
        err0 = err_seen;
        send_beat(8'h71);
        step();
        check("err pulse", bus.rx_err, 1'b1);
        step();
        check("err clears", bus.rx_err, 1'b0);
        check("err no write", bus.rx_count, 3'd0);
        check("err pulses", err_seen - err0, 1);
        rx_frame(4'd3, 4'd5, 8'h77, 16'h0000);
        step();
        pop_expect("after err", 4'd3, 4'd5, 8'h77, 16'h0000);

        // reset mid-frame on both sides
        rx_frame(4'd2, 4'd1, 8'h20, 16'h0000);
        step();
        check("pre-rst count", bus.rx_count, 3'd1);
        tx_req(4'd1, 4'd9, 8'hAA, 16'h7788);
        bus.fric_in = 8'h19;
        step();
        bus.tx_valid = 1'b0;
        bus.fric_in = 8'h33;
        step();
        bus.fric_in = 8'h44;
        step();
        check("pre-rst addr", bus.fric_out, 8'hAA);
        bus.fric_in = 8'h55;
        #2 rst = 1'b0;
        #1;
        check("rst fric_out now", bus.fric_out, 8'h00);
        check("rst count now",    bus.rx_count, 3'd0);
        check("rst tx_ready now", bus.tx_ready, 1'b1);
        bus.fric_in = 8'h00;
        #3 rst = 1'b1;
        err0 = err_seen;
        step();
        step();
        check("post-rst out", bus.fric_out, 8'h00);
        step();
        check("post-rst out2",  bus.fric_out, 8'h00);
        check("post-rst count", bus.rx_count, 3'd0);
        check("post-rst err",   err_seen - err0, 0);
        tx_req(4'd2, 4'd6, 8'h66, 16'h0000);
        step();
        bus.tx_valid = 1'b0;
        step(); check("post-rst hdr",  bus.fric_out, 8'h26);
        step(); check("post-rst addr", bus.fric_out, 8'h66);
        step(); check("post-rst idle", bus.fric_out, 8'h00);
        rx_frame(4'd3, 4'hC, 8'h99, 16'h0000);
        step();
        check("post-rst rx count", bus.rx_count, 3'd1);
        pop_expect("post-rst rx", 4'd3, 4'hC, 8'h99, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
